// File: rtl/cic_comp_fir.sv
// Droop-compensation FIR for the decimated CIC output: a single serial MAC
// walks the taps one per clock, then the result is rounded, saturated and strobed.
module cic_comp_fir #(
  parameter int                    WIDTH  = 8,
  parameter int                    NTAPS  = 3,
  parameter int                    CW     = 8,
  parameter logic [NTAPS*CW-1:0]   COEFFS = {8'hFE, 8'h14, 8'hFE},
  parameter int                    SHIFT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             overflow
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int AW = WIDTH + CW + $clog2(NTAPS) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0]      LAST_IDX = IW'(NTAPS - 1);
  localparam logic signed [AW:0] RND      = (AW+1)'(1) << (SHIFT - 1);
  localparam logic signed [AW:0] MAX_OUT  = {{(AW+1-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]        hist_q [NTAPS];
  logic [WIDTH-1:0]        hist_d [NTAPS];
  logic [WIDTH-1:0]        out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overflow_q, overflow_d;
  logic [CW-1:0]           coef_s;
  logic [WIDTH-1:0]        x_s;
  logic signed [AW-1:0]    prod_s;

  // Round half-up with arithmetic shift, then clamp to the unsigned output range.
  function automatic logic [WIDTH-1:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW:0] r;
    r = ($signed({a[AW-1], a}) + RND) >>> SHIFT;
    if (r[AW]) begin
      round_sat = {WIDTH{1'b0}};
    end else if (r > MAX_OUT) begin
      round_sat = {WIDTH{1'b1}};
    end else begin
      round_sat = r[WIDTH-1:0];
    end
  endfunction

  // Select the coefficient and history sample for the tap under processing.
  always_comb begin
    coef_s = {CW{1'b0}};
    x_s    = {WIDTH{1'b0}};
    for (int i = 0; i < NTAPS; i++) begin
      if (idx_q == i[IW-1:0]) begin
        coef_s = COEFFS[i*CW +: CW];
        x_s    = hist_q[i];
      end else begin
        coef_s = coef_s;
      end
    end
    prod_s = $signed({{(AW-CW){coef_s[CW-1]}}, coef_s}) *
             $signed({{(AW-WIDTH){1'b0}}, x_s});
  end

  // Next-state logic for the IDLE -> MAC -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    hist_d      = hist_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    if (in_valid && (state_q != IDLE)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hist_d[0] = in;
          for (int i = 1; i < NTAPS; i++) begin
            hist_d[i] = hist_q[i-1];
          end
          acc_d   = {AW{1'b0}};
          idx_d   = {IW{1'b0}};
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_s;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = MAC;
        end
      end
      DONE: begin
        out_d       = round_sat(acc_q);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= {IW{1'b0}};
      acc_q       <= {AW{1'b0}};
      out_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        hist_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < NTAPS; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed-vector bench for cic_comp_fir with default parameters
// (taps {-2, 20, -2}, SHIFT 4); expected outputs are hand-computed.
module tb_cic_comp_fir;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cic_comp_fir dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (din_valid),
    .out       (dout),
    .out_valid (dout_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; the strobe is sampled at the following posedge.
  task automatic strobe(input logic [7:0] v);
    din       = v;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 8'bx;
  endtask

  // Counts negedges until out_valid is seen; lat = -1 on timeout.
  task automatic capture(output logic [7:0] got, output int lat);
    lat = -1;
    got = 8'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dout_valid) begin
        lat = k;
        got = dout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    int lat;
    do_reset();
    strobe(8'd100); capture(got, lat);
    strobe(8'd100); capture(got, lat);
    n_checks++;
    if (got !== 8'd113) begin n_fail++; $display("FAIL reset_pre_out: got %0d want 113", got); end
    strobe(8'd100);
    @(negedge clk);
    strobe(8'd7);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_state: busy %b ovf %b want 1 1", busy, overflow);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dout !== 8'd0 || dout_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out %0d ov %b busy %b ovf %b want 0 0 0 0", dout, dout_valid, busy, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    strobe(8'd100); capture(got, lat);
    n_checks++;
    if (got !== 8'd0 || lat !== 4) begin
      n_fail++; $display("FAIL reset_first_out: got %0d lat %0d want 0 lat 4", got, lat);
    end
  endtask

  task automatic test_step();
    logic [7:0] exp_v [4] = '{8'd0, 8'd113, 8'd100, 8'd100};
    logic [7:0] got;
    int lat;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(8'd100);
      capture(got, lat);
      n_checks++;
      if (got !== exp_v[i] || lat !== 4) begin
        n_fail++; $display("FAIL step[%0d]: got %0d lat %0d want %0d lat 4", i, got, lat, exp_v[i]);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL step_busy[%0d]: got %b want 0", i, busy); end
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL step_pulse[%0d]: out_valid %b want 0", i, dout_valid); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_impulse_sat();
    logic [7:0] in_v  [7] = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
    logic [7:0] exp_v [7] = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255};
    logic [7:0] got;
    int lat;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      strobe(in_v[i]);
      capture(got, lat);
      n_checks++;
      if (got !== exp_v[i] || lat !== 4) begin
        n_fail++; $display("FAIL impulse[%0d]: got %0d lat %0d want %0d lat 4", i, got, lat, exp_v[i]);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    int lat;
    do_reset();
    strobe(8'd100);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b want 0", overflow); end
    strobe(8'd200);
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1 || dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_set: ovf %b ov %b want 1 0", overflow, dout_valid);
    end
    capture(got, lat);
    n_checks++;
    if (got !== 8'd0 || lat !== 1) begin
      n_fail++; $display("FAIL ovf_out: got %0d lat %0d want 0 lat 1", got, lat);
    end
    repeat (3) @(negedge clk);
    strobe(8'd100);
    capture(got, lat);
    n_checks++;
    if (got !== 8'd113) begin n_fail++; $display("FAIL ovf_dropped: got %0d want 113", got); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    int lat;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      strobe(8'd50);
      capture(got, lat);
      n_checks++;
      if (lat !== 4 || overflow !== 1'b0) begin
        n_fail++; $display("FAIL b2b[%0d]: lat %0d ovf %b want lat 4 ovf 0", i, lat, overflow);
      end
    end
    n_checks++;
    if (got !== 8'd50) begin n_fail++; $display("FAIL b2b_settle: got %0d want 50", got); end
  endtask

  task automatic test_reset_mid_mac();
    logic [7:0] got;
    int lat;
    do_reset();
    strobe(8'd100); capture(got, lat);
    strobe(8'd100); capture(got, lat);
    repeat (3) @(negedge clk);
    strobe(8'd100);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    capture(got, lat);
    n_checks++;
    if (lat !== -1) begin n_fail++; $display("FAIL midmac_abort: out_valid seen lat %0d want none", lat); end
    strobe(8'd100);
    capture(got, lat);
    n_checks++;
    if (got !== 8'd0 || lat !== 4) begin
      n_fail++; $display("FAIL midmac_restart: got %0d lat %0d want 0 lat 4", got, lat);
    end
  endtask

  initial begin
    rst       = 1'b1;
    din       = 8'd0;
    din_valid = 1'b0;
    #1;
    n_checks++;
    if (dout !== 8'd0 || dout_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL por: out %0d ov %b busy %b ovf %b want all 0", dout, dout_valid, busy, overflow);
    end
    test_reset();
    test_step();
    test_impulse_sat();
    test_overflow();
    test_back_to_back();
    test_reset_mid_mac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
